// File: rtl/mul_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mul_sequencer_pkg
// Purpose  : Shared definitions for the multiplier sequencer (state codes, widths)
// Revision : 1.0
// ----------------------------------------------------------------------------
package mul_sequencer_pkg;

  localparam int c_DEFAULT_WIDTH = 16;

  typedef logic [1:0] state_t;

  localparam state_t c_IDLE = 2'd0;
  localparam state_t c_RUN  = 2'd1;
  localparam state_t c_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mul_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mul_sequencer_if
// Purpose  : Two-requester multiply request/result bundle
// Revision : 1.0
// ----------------------------------------------------------------------------
interface mul_sequencer_if
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
);

  logic               iReq0;
  logic [WIDTH-1:0]   iA0;
  logic [WIDTH-1:0]   iB0;
  logic               iReq1;
  logic [WIDTH-1:0]   iA1;
  logic [WIDTH-1:0]   iB1;
  logic               oBusy;
  logic               oDone0;
  logic               oDone1;
  logic [2*WIDTH-1:0] oResult;

  modport master (
    output iReq0, iA0, iB0, iReq1, iA1, iB1,
    input  oBusy, oDone0, oDone1, oResult
  );

  modport slave (
    input  iReq0, iA0, iB0, iReq1, iA1, iB1,
    output oBusy, oDone0, oDone1, oResult
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : rr_arbiter2
// Purpose  : Two-input round-robin grant with a registered last-grant bit
// Revision : 1.0
// ----------------------------------------------------------------------------
module rr_arbiter2 (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic iReq0,
  input  wire logic iReq1,
  input  wire logic iTake,
  output logic      oValid,
  output logic      oGrant
);

  logic rLastGrant;

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    oValid = iReq0 | iReq1;
    if (iReq0 && iReq1) begin
      oGrant = ~rLastGrant;
    end else begin
      oGrant = iReq1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rLastGrant <= 1'b1;
    end else if (iTake) begin
      rLastGrant <= oGrant;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mul_sequencer
// Purpose  : Shared shift-add multiplier serving two requesters, fixed WIDTH-cycle latency
// Revision : 1.0
// ----------------------------------------------------------------------------
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  wire logic      clk,
  input  wire logic      rst,
  mul_sequencer_if.slave bus
);

  localparam int c_CNT_W = $clog2(WIDTH) + 1;

  state_t             rState;
  state_t             wNextState;
  logic               wGrantValid;
  logic               wGrant;
  logic               rGrant;
  logic               wCapture;
  logic               wLastStep;
  logic [2*WIDTH-1:0] rMcand;
  logic [WIDTH-1:0]   rMplier;
  logic [2*WIDTH-1:0] rAcc;
  logic [2*WIDTH-1:0] wAccNext;
  logic [2*WIDTH-1:0] rResult;
  logic [c_CNT_W-1:0] rCnt;
  logic [WIDTH-1:0]   wSelA;
  logic [WIDTH-1:0]   wSelB;
  logic               wBusy;
  logic               wDone0;
  logic               wDone1;

  rr_arbiter2 uArb (
    .clk    (clk),
    .rst    (rst),
    .iReq0  (bus.iReq0),
    .iReq1  (bus.iReq1),
    .iTake  (wCapture),
    .oValid (wGrantValid),
    .oGrant (wGrant)
  );

  assign wCapture  = (rState == c_IDLE) && wGrantValid;
  assign wLastStep = (rState == c_RUN) && (rCnt == c_CNT_W'(WIDTH - 1));
  assign wSelA     = wGrant ? bus.iA1 : bus.iA0;
  assign wSelB     = wGrant ? bus.iB1 : bus.iB0;
  assign wAccNext  = rMplier[0] ? (rAcc + rMcand) : rAcc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rState <= c_IDLE;
    end else begin
      rState <= wNextState;
    end
  end

  always_comb begin
    wNextState = rState;
    case (rState)
      c_IDLE:  if (wGrantValid) wNextState = c_RUN;
      c_RUN:   if (wLastStep)   wNextState = c_DONE;
      c_DONE:  wNextState = c_IDLE;
      default: wNextState = c_IDLE;
    endcase
  end

  always_comb begin
    wBusy  = (rState != c_IDLE);
    wDone0 = (rState == c_DONE) && !rGrant;
    wDone1 = (rState == c_DONE) &&  rGrant;
  end

  // The final step's sum goes straight to the result so DONE follows the WIDTH-th edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rGrant  <= 1'b0;
      rMcand  <= '0;
      rMplier <= '0;
      rAcc    <= '0;
      rCnt    <= '0;
      rResult <= '0;
    end else if (wCapture) begin
      rGrant  <= wGrant;
      rMcand  <= {{WIDTH{1'b0}}, wSelA};
      rMplier <= wSelB;
      rAcc    <= '0;
      rCnt    <= '0;
    end else if (rState == c_RUN) begin
      rAcc    <= wAccNext;
      rMcand  <= rMcand << 1;
      rMplier <= rMplier >> 1;
      rCnt    <= rCnt + c_CNT_W'(1);
      if (wLastStep) begin
        rResult <= wAccNext;
      end
    end
  end

  assign bus.oBusy   = wBusy;
  assign bus.oDone0  = wDone0;
  assign bus.oDone1  = wDone1;
  assign bus.oResult = rResult;

endmodule
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_mul_sequencer
// Purpose  : Scoreboard testbench for mul_sequencer
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_mul_sequencer;

  localparam int W = 16;

  typedef struct packed {
    logic [1:0]     who;
    logic [2*W-1:0] prod;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cycle;
  int   capCycle;
  bit   prevBusy;
  bit   prevDone;
  exp_t sb[$];

  mul_sequencer_if #(.WIDTH(W)) bus ();

  mul_sequencer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Output side of the scoreboard: every done pulse is matched against the queue.
  always @(negedge clk) begin
    if (rst) begin
      prevBusy = 1'b0;
      prevDone = 1'b0;
    end else begin
      if (bus.oBusy && !prevBusy) capCycle = cycle;
      if (bus.oDone0 || bus.oDone1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done got done1/done0=%b%b required none", bus.oDone1, bus.oDone0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checks++;
          if ({bus.oDone1, bus.oDone0} !== e.who) begin
            errors++;
            $display("FAIL done_requester got %b required %b", {bus.oDone1, bus.oDone0}, e.who);
          end
          checks++;
          if (bus.oResult !== e.prod) begin
            errors++;
            $display("FAIL result got %h required %h", bus.oResult, e.prod);
          end
          checks++;
          if ((cycle - capCycle) != W) begin
            errors++;
            $display("FAIL latency got %0d required %0d", cycle - capCycle, W);
          end
        end
        checks++;
        if (prevDone) begin
          errors++;
          $display("FAIL done_width got 2+ cycles required 1");
        end
      end
      prevBusy = bus.oBusy;
      prevDone = bus.oDone0 || bus.oDone1;
    end
  end

  task automatic wait_done(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((which == 0) ? bus.oDone0 : bus.oDone1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", bus.oBusy); end
    checks++;
    if ({bus.oDone1, bus.oDone0} !== 2'b00) begin errors++; $display("FAIL reset_done got %b required 00", {bus.oDone1, bus.oDone0}); end
    checks++;
    if (bus.oResult !== '0) begin errors++; $display("FAIL reset_result got %h required 0", bus.oResult); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b required 0", bus.oBusy); end
  endtask

  task automatic test_basic();
    bit ok;
    @(negedge clk);
    bus.iA0 = 16'd3; bus.iB0 = 16'd5; bus.iReq0 = 1'b1;
    sb.push_back('{who: 2'b01, prod: 32'd15});
    @(posedge clk); #1;
    checks++;
    if (bus.oBusy !== 1'b1) begin errors++; $display("FAIL busy_after_capture got %b required 1", bus.oBusy); end
    wait_done(0, ok);
    bus.iReq0 = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout got no done0 required done0"); end
  endtask

  task automatic test_extremes();
    bit ok;
    @(negedge clk);
    bus.iA1 = 16'hFFFF; bus.iB1 = 16'hFFFF; bus.iReq1 = 1'b1;
    sb.push_back('{who: 2'b10, prod: 32'hFFFE0001});
    wait_done(1, ok);
    bus.iReq1 = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL ffff_timeout got no done1 required done1"); end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.oResult !== 32'hFFFE0001) begin errors++; $display("FAIL result_hold got %h required fffe0001", bus.oResult); end
    bus.iA1 = 16'h0000; bus.iB1 = 16'h1234; bus.iReq1 = 1'b1;
    sb.push_back('{who: 2'b10, prod: 32'd0});
    wait_done(1, ok);
    bus.iReq1 = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL zero_timeout got no done1 required done1"); end
  endtask

  task automatic test_round_robin();
    int n;
    do_reset();
    @(negedge clk);
    bus.iA0 = 16'd100;  bus.iB0 = 16'd200;
    bus.iA1 = 16'h8001; bus.iB1 = 16'd3;
    bus.iReq0 = 1'b1; bus.iReq1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) sb.push_back('{who: 2'b01, prod: 32'd20000});
      else            sb.push_back('{who: 2'b10, prod: 32'h00018003});
    end
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.oDone0 || bus.oDone1) n++;
      if (n == 4) break;
    end
    bus.iReq0 = 1'b0; bus.iReq1 = 1'b0;
    checks++;
    if (n != 4) begin errors++; $display("FAIL rr_count got %0d required 4", n); end
  endtask

  task automatic test_reset_midrun();
    bit ok;
    @(negedge clk);
    bus.iA0 = 16'd9; bus.iB0 = 16'd9; bus.iReq0 = 1'b1;
    sb.push_back('{who: 2'b01, prod: 32'd81});
    @(posedge clk);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    void'(sb.pop_back());
    #1;
    bus.iReq0 = 1'b0;
    checks++;
    if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b required 0", bus.oBusy); end
    checks++;
    if (bus.oResult !== '0) begin errors++; $display("FAIL abort_result got %h required 0", bus.oResult); end
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.oDone1, bus.oDone0} !== 2'b00) begin errors++; $display("FAIL abort_done got %b required 00", {bus.oDone1, bus.oDone0}); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    bus.iA0 = 16'd6; bus.iB0 = 16'd7; bus.iReq0 = 1'b1;
    sb.push_back('{who: 2'b01, prod: 32'd42});
    wait_done(0, ok);
    bus.iReq0 = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL post_abort_timeout got no done0 required done0"); end
  endtask

  task automatic test_busy_queue();
    bit ok;
    @(negedge clk);
    bus.iA0 = 16'd7; bus.iB0 = 16'd9; bus.iReq0 = 1'b1;
    sb.push_back('{who: 2'b01, prod: 32'd63});
    repeat (4) @(negedge clk);
    bus.iA1 = 16'd11; bus.iB1 = 16'd13; bus.iReq1 = 1'b1;
    sb.push_back('{who: 2'b10, prod: 32'd143});
    bus.iA0 = 16'hDEAD; bus.iB0 = 16'hBEEF;
    wait_done(0, ok);
    bus.iReq0 = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL queue_done0_timeout got no done0 required done0"); end
    @(posedge clk); #1;
    checks++;
    if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL queue_idle got busy=%b required 0", bus.oBusy); end
    @(posedge clk); #1;
    checks++;
    if (bus.oBusy !== 1'b1) begin errors++; $display("FAIL queue_capture got busy=%b required 1", bus.oBusy); end
    wait_done(1, ok);
    bus.iReq1 = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL queue_done1_timeout got no done1 required done1"); end
  endtask

  initial begin
    checks = 0; errors = 0; cycle = 0; capCycle = 0;
    prevBusy = 1'b0; prevDone = 1'b0;
    rst = 1'b0;
    bus.iReq0 = 1'b0; bus.iA0 = '0; bus.iB0 = '0;
    bus.iReq1 = 1'b0; bus.iA1 = '0; bus.iB1 = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_round_robin();
    test_reset_midrun();
    test_busy_queue();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d pending required 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter: WIDTH, default 16, operand width in bits; result width is 2*WIDTH.
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 iReq0  input  1  requester 0 multiply request, level; held until oDone0.
REQ-005 iA0, iB0  input  WIDTH each  requester 0 operands.
REQ-006 iReq1  input  1  requester 1 multiply request, level; held until oDone1.
REQ-007 iA1, iB1  input  WIDTH each  requester 1 operands.
REQ-008 oBusy  output  1  high in every state except IDLE; used to stall the instruction pointer.
REQ-009 oDone0  output  1  one-cycle pulse: requester 0 result valid.
REQ-010 oDone1  output  1  one-cycle pulse: requester 1 result valid.
REQ-011 oResult  output  2*WIDTH  unsigned product of the last served request.

Function
REQ-012 States SHALL be IDLE, RUN and DONE only.
REQ-013 IDLE: on a rising edge with any iReq high, grant one requester.
- Capture that requester's operands.
- Clear accumulator and cycle counter.
- Go to RUN.
REQ-014 Arbitration SHALL be round-robin over a registered last-grant bit.
- Both requesting: grant the requester not served last.
- One requesting: grant it regardless of last-grant.
REQ-015 RUN: each edge performs one shift-add step.
- If multiplier LSB=1, add the shifted multiplicand to the accumulator.
- Shift multiplier right 1, multiplicand left 1.
- Increment counter.
REQ-016 RUN SHALL last exactly WIDTH edges; the WIDTH-th edge loads oResult and goes to DONE.
REQ-017 Latency SHALL be fixed at WIDTH cycles from capture edge to oDone high, independent of operand values, including zero.
REQ-018 DONE: assert exactly one oDoneN for the granted requester for one cycle, then go to IDLE unconditionally.
REQ-019 iReq sampled in DONE or RUN SHALL be ignored; a request arriving while busy waits and is served from IDLE.
REQ-020 Operand or iReq changes after capture SHALL NOT affect the product in progress.
REQ-021 oResult SHALL hold its value until the next transition into DONE.
REQ-022 Arithmetic SHALL be unsigned, 2*WIDTH wide, with no overflow or truncation.
REQ-023 A requester SHALL deassert iReq by the edge following its oDone pulse; if it keeps iReq high, it is re-served under REQ-014.

Reset
REQ-024 Reset SHALL force, asynchronously:
- State to IDLE.
- Counter, accumulator and operand registers to 0.
- oResult to 0; oBusy, oDone0 and oDone1 to 0.
- Last-grant to requester 1, so requester 0 wins the first tie.
REQ-025 Reset during RUN or DONE SHALL abort the operation with no oDone pulse; after release, the block accepts requests from IDLE.

Structure
REQ-026 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default SHALL live in the shared definitions include used by the ALU opcodes.
REQ-027 The two-input round-robin grant logic SHALL be one sub-module, rr_arbiter2; the FSM and shift-add datapath stay in mul_sequencer.

Verification
REQ-028 After reset: iReq0=1, iA0=3, iB0=5.
- oBusy rises after the capture edge.
- oDone0 pulses 16 cycles after capture; oResult=15.
- oDone1 stays 0.
REQ-029 iReq1=1, iA1=16'hFFFF, iB1=16'hFFFF -> oResult=32'hFFFE0001 with a single oDone1 pulse; then iA1=0, iB1=16'h1234 -> oResult=0, same 16-cycle latency.
REQ-030 After reset, iReq0 and iReq1 rise together.
- Requester 0 is served first, then requester 1.
- Both held high: grants alternate 0,1,0,1 across four operations.
REQ-031 Assert Reset at RUN counter=7 -> immediately:
- State IDLE, oBusy=0, oResult=0.
- No oDone pulse.
- A new request afterwards completes normally in 16 cycles.
REQ-032 iReq1 rises while requester 0 is in RUN -> requester 1 is captured only at the first IDLE edge after oDone0; operand changes on port 0 mid-RUN leave its result unchanged.
